// File: rtl/commit_trace_unit.sv
// commit_trace_unit: captures one commit record per retired instruction,
// buffers it in a small FIFO and streams it out on a val/rdy interface.
// The producer is back-pressured through a registered commit_rdy.
module commit_trace_unit #(
  parameter int DEPTH = 4,
  parameter int SEQ_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             commit_val,
  output logic             commit_rdy,
  input  logic [31:0]      commit_pc,
  input  logic [4:0]       commit_waddr,
  input  logic [31:0]      commit_wdata,
  input  logic             commit_wen,
  output logic             trace_val,
  input  logic             trace_rdy,
  output logic [31:0]      trace_pc,
  output logic [4:0]       trace_waddr,
  output logic [31:0]      trace_wdata,
  output logic             trace_wen,
  output logic [SEQ_W-1:0] trace_seq,
  output logic [31:0]      num_commits
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]      pc_q    [DEPTH];
  logic [4:0]       waddr_q [DEPTH];
  logic [31:0]      wdata_q [DEPTH];
  logic             wen_q   [DEPTH];
  logic [SEQ_W-1:0] seq_q   [DEPTH];

  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rdy_q;
  logic [SEQ_W-1:0] seq_ctr_q;
  logic [31:0]      ncommit_q;
  logic             push, pop;

  assign push = commit_val & rdy_q;
  assign pop  = (cnt_q != '0) & trace_rdy;

  // Occupancy after this cycle's handshakes; a push blocked by full is
  // already excluded because push is qualified by the registered ready.
  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state: pointers, count, ready, sequence and commit counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      rdy_q     <= 1'b0;
      seq_ctr_q <= '0;
      ncommit_q <= '0;
    end else begin
      if (push) begin
        wptr_q    <= wptr_q + AW'(1);
        seq_ctr_q <= seq_ctr_q + SEQ_W'(1);
        if (ncommit_q != 32'hFFFF_FFFF) ncommit_q <= ncommit_q + 32'd1;
      end
      if (pop) rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_d;
      rdy_q <= (cnt_d != FULL_CNT);
    end
  end

  // Record storage; cleared on reset so the head reads zero while in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        waddr_q[i] <= '0;
        wdata_q[i] <= '0;
        wen_q[i]   <= 1'b0;
        seq_q[i]   <= '0;
      end
    end else if (push) begin
      pc_q[wptr_q]    <= commit_pc;
      waddr_q[wptr_q] <= commit_waddr;
      wdata_q[wptr_q] <= commit_wdata;
      // Writes to x0 are architecturally dropped, so the record says no write.
      wen_q[wptr_q]   <= commit_wen & (commit_waddr != 5'd0);
      seq_q[wptr_q]   <= seq_ctr_q;
    end
  end

  assign commit_rdy  = rdy_q;
  assign trace_val   = (cnt_q != '0);
  assign trace_pc    = pc_q[rptr_q];
  assign trace_waddr = waddr_q[rptr_q];
  assign trace_wdata = wdata_q[rptr_q];
  assign trace_wen   = wen_q[rptr_q];
  assign trace_seq   = seq_q[rptr_q];
  assign num_commits = ncommit_q;

endmodule

// File: tb/tb_commit_trace_unit.sv
// Scoreboard bench for commit_trace_unit (DEPTH=4, SEQ_W=4 so wrap is reachable).
module tb_commit_trace_unit;
  localparam int DEPTH = 4;
  localparam int SEQ_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic commit_val = 1'b0, commit_rdy;
  logic [31:0] commit_pc = '0, commit_wdata = '0;
  logic [4:0]  commit_waddr = '0;
  logic commit_wen = 1'b0;
  logic trace_val, trace_rdy = 1'b0;
  logic [31:0] trace_pc, trace_wdata, num_commits;
  logic [4:0]  trace_waddr;
  logic trace_wen;
  logic [SEQ_W-1:0] trace_seq;

  commit_trace_unit #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
    .clk(clk), .rst(rst),
    .commit_val(commit_val), .commit_rdy(commit_rdy),
    .commit_pc(commit_pc), .commit_waddr(commit_waddr),
    .commit_wdata(commit_wdata), .commit_wen(commit_wen),
    .trace_val(trace_val), .trace_rdy(trace_rdy),
    .trace_pc(trace_pc), .trace_waddr(trace_waddr),
    .trace_wdata(trace_wdata), .trace_wen(trace_wen),
    .trace_seq(trace_seq), .num_commits(num_commits)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        wen;
    logic [3:0]  seq;
  } rec_t;

  rec_t q[$];
  int   cmp_n = 0;
  int   mism_n = 0;
  int   mseq = 0;
  longint mnum = 0;
  bit   edge_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      mism_n++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Ready can only rise once a rising edge has been seen with reset released.
  always @(posedge clk) if (rst) edge_seen = 1'b1;

  // Monitor: compare head against scoreboard, then log pops and pushes that
  // will take effect at the coming rising edge.
  always @(negedge clk) begin
    if (rst) begin
      int sz;
      rec_t e, n;
      sz = q.size();
      chk("trace_val", 32'(trace_val), 32'(sz != 0));
      chk("commit_rdy", 32'(commit_rdy), 32'(edge_seen && (sz != DEPTH)));
      chk("num_commits", num_commits, 32'(mnum));
      if (trace_val && sz > 0) begin
        e = q[0];
        chk("trace_pc", trace_pc, e.pc);
        chk("trace_waddr", 32'(trace_waddr), 32'(e.wa));
        chk("trace_wdata", trace_wdata, e.wd);
        chk("trace_wen", 32'(trace_wen), 32'(e.wen));
        chk("trace_seq", 32'(trace_seq), 32'(e.seq));
        if (trace_rdy) void'(q.pop_front());
      end
      if (commit_val && commit_rdy) begin
        n.pc  = commit_pc;
        n.wa  = commit_waddr;
        n.wd  = commit_wdata;
        n.wen = commit_wen && (commit_waddr != 5'd0);
        n.seq = 4'(mseq % 16);
        q.push_back(n);
        mseq++;
        if (mnum < 64'hFFFF_FFFF) mnum++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset pulse between edges; scoreboard is flushed at the same moment.
  task automatic do_reset();
    @(posedge clk);
    #2;
    commit_val = 1'b0;
    rst = 1'b0;
    q.delete();
    mseq = 0;
    mnum = 0;
    edge_seen = 1'b0;
    #1;
    chk("rst_trace_val", 32'(trace_val), 32'd0);
    chk("rst_commit_rdy", 32'(commit_rdy), 32'd0);
    chk("rst_trace_pc", trace_pc, 32'd0);
    chk("rst_num_commits", num_commits, 32'd0);
    tick();
    tick();
    #1;
    rst = 1'b1;
    tick();
  endtask

  // Present a record and hold it until accepted (bounded wait).
  task automatic push(input logic [31:0] pc, input logic [4:0] wa,
                      input logic [31:0] wd, input logic wen);
    bit acc;
    commit_pc = pc; commit_waddr = wa; commit_wdata = wd; commit_wen = wen;
    commit_val = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) begin
      acc = commit_rdy;
      tick();
    end
    commit_val = 1'b0;
    if (!acc) begin
      cmp_n++;
      mism_n++;
      $display("FAIL push_timeout: got no accept expected accept within 200 cycles");
    end
  endtask

  initial begin
    bit acc;
    #22;
    rst = 1'b1;
    tick();

    // 1. single record
    do_reset();
    trace_rdy = 1'b1;
    push(32'h200, 5'd5, 32'h1234, 1'b1);
    chk("t1_val_next_cycle", 32'(trace_val), 32'd1);
    chk("t1_seq", 32'(trace_seq), 32'd0);
    chk("t1_num", num_commits, 32'd1);
    tick();

    // 2. x0 suppression
    push(32'h300, 5'd0, 32'hDEADBEEF, 1'b1);
    chk("t2_wen", 32'(trace_wen), 32'd0);
    chk("t2_wdata", trace_wdata, 32'hDEADBEEF);
    tick();

    // 3. fill and back-pressure
    do_reset();
    trace_rdy = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h200 + 32'(4 * i), 5'(i + 1), 32'(i), 1'b1);
    chk("t3_rdy_full", 32'(commit_rdy), 32'd0);
    commit_pc = 32'h210; commit_waddr = 5'd7; commit_wdata = 32'h55; commit_wen = 1'b1;
    commit_val = 1'b1;
    tick(); tick(); tick();
    chk("t3_held_rdy", 32'(commit_rdy), 32'd0);
    chk("t3_num_held", num_commits, 32'd4);
    trace_rdy = 1'b1;
    push(32'h210, 5'd7, 32'h55, 1'b1);
    repeat (8) tick();

    // 4. full-state push and pop
    do_reset();
    trace_rdy = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h400 + 32'(4 * i), 5'd3, 32'(i), 1'b0);
    commit_pc = 32'h410; commit_waddr = 5'd9; commit_wdata = 32'h99; commit_wen = 1'b1;
    commit_val = 1'b1;
    trace_rdy = 1'b1;
    tick();
    trace_rdy = 1'b0;
    chk("t4_rdy_after_pop", 32'(commit_rdy), 32'd1);
    chk("t4_num_no_push", num_commits, 32'd4);
    push(32'h410, 5'd9, 32'h99, 1'b1);
    chk("t4_num_after", num_commits, 32'd5);
    trace_rdy = 1'b1;
    repeat (8) tick();

    // 5. sequence wrap
    do_reset();
    trace_rdy = 1'b1;
    for (int i = 0; i < 18; i++) push(32'h1000 + 32'(4 * i), 5'(i), 32'($urandom), 1'b1);
    tick();
    chk("t5_num", num_commits, 32'd18);
    repeat (4) tick();

    // 6. reset mid-operation
    trace_rdy = 1'b0;
    for (int i = 0; i < 3; i++) push(32'h500 + 32'(4 * i), 5'd2, 32'(i), 1'b1);
    chk("t6_val_before", 32'(trace_val), 32'd1);
    do_reset();
    trace_rdy = 1'b1;
    push(32'h600, 5'd4, 32'h66, 1'b1);
    chk("t6_seq", 32'(trace_seq), 32'd0);
    chk("t6_num", num_commits, 32'd1);
    tick();

    // randomized traffic with a producer that holds unaccepted records
    commit_val = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!commit_val || acc) begin
        commit_val   = ($urandom_range(0, 3) != 0);
        commit_pc    = $urandom;
        commit_waddr = 5'($urandom_range(0, 31));
        commit_wdata = $urandom;
        commit_wen   = 1'($urandom_range(0, 1));
      end
      trace_rdy = ($urandom_range(0, 2) != 0);
      acc = commit_val && commit_rdy;
      tick();
    end
    commit_val = 1'b0;
    trace_rdy = 1'b1;
    repeat (10) tick();
    chk("final_drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, mism_n);
    $finish;
  end
endmodule

// File: doc/commit_trace_unit.md
Name: commit_trace_unit

Overview:
- Producer side of the per-instruction commit trace (pc, waddr, wdata, wen) that the processor test benches consume and check.
- Sits at the writeback stage of the RTL processor and captures one record per retired instruction.
- Buffers records in a small FIFO and presents them on a val/rdy stream, so a checker or trace sink can stall without losing commits.
- Back-pressures the processor when the buffer is full.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- SEQ_W, 16, width of the per-record sequence number.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- commit_val  input  1  the processor retires an instruction this cycle.
- commit_rdy  output  1  the unit can accept a record.
- commit_pc  input  32  PC of the retiring instruction.
- commit_waddr  input  5  destination register.
- commit_wdata  input  32  writeback data.
- commit_wen  input  1  the instruction writes the register file.
- trace_val  output  1  a record is available.
- trace_rdy  input  1  the sink accepts the record.
- trace_pc  output  32  record PC.
- trace_waddr  output  5  record destination register.
- trace_wdata  output  32  record data.
- trace_wen  output  1  record write-enable.
- trace_seq  output  SEQ_W  sequence number of the record.
- num_commits  output  32  total records accepted since reset.

Behaviour:
- Reset (rst low, asynchronous): FIFO empties; all pointers, the count, the sequence counter and num_commits go to 0.
- Output values during reset: trace_val=0, commit_rdy=0, and all trace_* data fields read 0.
- Releasing reset: commit_rdy rises to 1 on the first clock edge after rst goes high.
- Push handshake: a record is pushed when commit_val and commit_rdy are both high at the clock edge.
- commit_rdy is registered and equals !full; there is no combinational path from trace_rdy to commit_rdy.
- Pop handshake: a record is popped when trace_val and trace_rdy are both high.
- trace_val equals !empty.
- trace_* always show the head entry, read directly from FIFO storage with no mux-dependent bubbles.
- Latency: a record pushed at edge N is visible on trace_* in the cycle after edge N. There is no same-cycle bypass when the FIFO is empty.
- x0 rule: if commit_wen=1 and commit_waddr=0, the stored wen is 0. waddr and wdata are still stored unchanged.
- wen=0 rule: if commit_wen=0, waddr and wdata are stored as given. A sink must ignore them.
- Sequence numbers: each pushed record is tagged with seq_ctr, and seq_ctr then increments. It wraps modulo 2^SEQ_W from all-ones to 0.
- num_commits increments on every push and saturates at 0xFFFFFFFF.
- Simultaneous push and pop when neither full nor empty: both occur and the count is unchanged.
- Simultaneous push and pop when full: only the pop occurs (commit_rdy was 0), and commit_rdy rises the next cycle.
- Simultaneous push and pop when empty: only the push occurs.
- Pointer wrap: read and write pointers are log2(DEPTH) bits and wrap naturally. Full and empty are derived from an explicit count register of width log2(DEPTH)+1.
- Stability: while trace_val=1 and trace_rdy=0, all trace_* outputs hold stable.
- Input rule: commit_val=1 with commit_rdy=0 is legal. The record is not captured and the producer must hold it.
- Reset in mid-operation: asserting rst discards all buffered records immediately. trace_val drops asynchronously, and sequence numbering restarts at 0 after release.

Test Plan:
1. Single record
   - Stimulus: reset, then push pc=0x200, waddr=5, wdata=0x1234, wen=1, with trace_rdy=1.
   - Required response: trace_val=1 exactly one cycle later with those fields and seq=0; num_commits=1.
2. x0 suppression
   - Stimulus: push waddr=0, wdata=0xDEADBEEF, wen=1.
   - Required response: the output record has wen=0, waddr=0, wdata=0xDEADBEEF.
3. Fill and back-pressure
   - Stimulus: trace_rdy=0 and push 5 records with pc=0x200,0x204,...
   - Required response: commit_rdy=0 after the 4th push; the 5th record is held off. After setting trace_rdy=1, records drain in order with seq 0..4 and pc 0x200..0x210.
4. Full-state push and pop
   - Stimulus: with the FIFO full, assert commit_val and trace_rdy together.
   - Required response: only the pop happens that cycle, commit_rdy=1 the next cycle, and no record is lost or duplicated.
5. Sequence wrap
   - Stimulus: with SEQ_W=4 and the sink always ready, stream 18 records.
   - Required response: seq runs 0..15, 0, 1, and num_commits=18.
6. Reset mid-operation
   - Stimulus: with 3 records buffered, pulse rst low between clock edges.
   - Required response: trace_val=0 immediately; after release, the next push yields seq=0 and num_commits=1.
